// File: rtl/seq_match_ctrl.sv
// Serial pattern matcher with run control: counts matches of a 1..8 bit pattern
// in a gated bit stream, with optional overlap and an optional match limit.
module seq_match_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pattern,
    input  logic [2:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       pattern_q, pattern_d;
    logic [2:0]       len_q, len_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [7:0]       history_q, history_d;
    logic [3:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0]       windowBits;
    logic [7:0]       lenMask;
    logic [3:0]       fillPlusOne;
    logic [3:0]       lenFull;
    logic [CNT_W-1:0] cntInc;
    logic             match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            history_q <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            limit_q   <= limit_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
        end
    end

    // The window includes the bit arriving this cycle, so z is a Mealy output.
    always_comb begin
        windowBits  = {history_q[6:0], x};
        lenMask     = 8'hFF >> (3'd7 - len_q);
        fillPlusOne = fill_q + 4'd1;
        lenFull     = {1'b0, len_q} + 4'd1;
        cntInc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        match       = (state_q == RUN) && x_valid && (fillPlusOne >= lenFull) &&
                      (((windowBits ^ pattern_q) & lenMask) == 8'd0);
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        limit_d   = limit_q;
        history_d = history_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    limit_d   = cfg_limit;
                end
                if (start) begin
                    state_d   = RUN;
                    history_d = '0;
                    fill_d    = '0;
                    cnt_d     = '0;
                end
            end
            RUN: begin
                if (x_valid) begin
                    history_d = windowBits;
                    if (match && !overlap_q) begin
                        fill_d = 4'd0;
                    end else if (fill_q != 4'd8) begin
                        fill_d = fillPlusOne;
                    end
                end
                if (match) begin
                    cnt_d = cntInc;
                end
                // A stop wins over reaching the limit; the match itself still counts.
                if (stop) begin
                    state_d = IDLE;
                end else if (match && (limit_q != '0) && (cntInc == limit_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign z         = match;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign match_cnt = cnt_q;

endmodule
